// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Serial transmitter that drains a byte FIFO onto a UART line. One byte is
// pulled per frame. The frame is a start bit, 8 data bits sent LSB first, an
// optional parity bit and one or two stop bits. The line idles high.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   PARITY        0 = none, 1 = even, 2 = odd
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   tx_en       allows a new frame to start; only looked at while idle
//   fifo_empty  FIFO empty flag; only looked at while idle
//   fifo_data   FIFO data_out, valid the cycle after a read edge
//   fifo_read   one-cycle read strobe to the FIFO
//   tx          serial line output
//   busy        high whenever the transmitter is not idle
//   frame_done  one-cycle pulse after the last stop bit
//
// All outputs are registered. Between back-to-back frames the line stays high
// for exactly three cycles (IDLE, REQ, LOAD).
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   baud_cnt, baud_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            parity_bit, parity_next;
  logic            tx_next;
  logic            read_next;
  logic            busy_next;
  logic            done_next;
  logic            baud_tc;

  assign baud_tc = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so that the registered tx changes on the same edge as the state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next   = state;
    baud_next    = baud_cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    parity_next  = parity_bit;
    tx_next      = tx;
    read_next    = 1'b0;
    done_next    = 1'b0;

    unique case (state)
      S_IDLE: begin
        tx_next      = 1'b1;
        baud_next    = '0;
        bit_idx_next = '0;
        if (tx_en && !fifo_empty) begin
          state_next = S_REQ;
          read_next  = 1'b1;
        end
      end

      // The FIFO advances on the edge that closes this cycle; its data_out
      // is therefore valid during LOAD.
      S_REQ: begin
        state_next = S_LOAD;
      end

      S_LOAD: begin
        shift_next  = fifo_data;
        parity_next = (^fifo_data) ^ (PARITY == 2);
        tx_next     = 1'b0;
        state_next  = S_START;
      end

      S_START: begin
        if (baud_tc) begin
          baud_next    = '0;
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
          state_next   = S_DATA;
        end else begin
          baud_next = baud_cnt + CW'(1);
        end
      end

      // shift_reg[0] is the bit currently on the line; the next bit to send
      // is shift_reg[1] until the shift happens.
      S_DATA: begin
        if (baud_tc) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_next = '0;
            if (PARITY != 0) begin
              tx_next    = parity_bit;
              state_next = S_PARITY;
            end else begin
              tx_next    = 1'b1;
              state_next = S_STOP;
            end
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
            tx_next      = shift_reg[1];
          end
        end else begin
          baud_next = baud_cnt + CW'(1);
        end
      end

      S_PARITY: begin
        if (baud_tc) begin
          baud_next    = '0;
          bit_idx_next = '0;
          tx_next      = 1'b1;
          state_next   = S_STOP;
        end else begin
          baud_next = baud_cnt + CW'(1);
        end
      end

      // bit_idx counts stop bits here.
      S_STOP: begin
        tx_next = 1'b1;
        if (baud_tc) begin
          baud_next = '0;
          if (bit_idx == 3'(STOP_BITS - 1)) begin
            bit_idx_next = '0;
            done_next    = 1'b1;
            state_next   = S_IDLE;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + CW'(1);
        end
      end

      default: begin
        tx_next    = 1'b1;
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      tx         <= 1'b1;
      fifo_read  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_idx    <= bit_idx_next;
      tx         <= tx_next;
      fifo_read  <= read_next;
      busy       <= busy_next;
      frame_done <= done_next;
    end
  end

  // NOTE: the data path needs no reset: it is always loaded in LOAD before
  // any of it reaches the line.
  always_ff @(posedge clk) begin
    shift_reg  <= shift_next;
    parity_bit <= parity_next;
  end

endmodule
